// File: rtl/feistel_engine_if.sv
// Block handshake and data bundle between the packet buffer, feistel_engine and the output stage.
// iv_load/iv_in exist only when FEISTEL_CBC_EN is defined.
interface feistel_engine_if #(
    parameter int HALF_W = 32,
    parameter int ROUNDS = 16
);
    logic                     start;
    logic                     mode;
    logic                     abort;
    logic [2*HALF_W-1:0]      data_in;
    logic [ROUNDS*HALF_W-1:0] round_keys;
    logic                     busy;
    logic                     done;
    logic [2*HALF_W-1:0]      data_out;
`ifdef FEISTEL_CBC_EN
    logic                     iv_load;
    logic [2*HALF_W-1:0]      iv_in;

    modport master (output start, mode, abort, data_in, round_keys, iv_load, iv_in,
                    input  busy, done, data_out);
    modport slave  (input  start, mode, abort, data_in, round_keys, iv_load, iv_in,
                    output busy, done, data_out);
`else
    modport master (output start, mode, abort, data_in, round_keys,
                    input  busy, done, data_out);
    modport slave  (input  start, mode, abort, data_in, round_keys,
                    output busy, done, data_out);
`endif
endinterface

// File: rtl/feistel_engine.sv
// Iterative Feistel cipher: RPC rounds per clock, done pulses ROUNDS/RPC cycles after start; start ignored while busy.
// Optional CBC chaining is compiled in with FEISTEL_CBC_EN.
module feistel_engine #(
    parameter int HALF_W = 32,
    parameter int ROUNDS = 16,
    parameter int RPC    = 1
) (
    input  logic            clk,
    input  logic            n_rst,
    feistel_engine_if.slave bus
);
    localparam int               BLK_W    = 2 * HALF_W;
    localparam int               CNT_W    = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - RPC);
    localparam logic [CNT_W-1:0] STEP     = CNT_W'(RPC);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              accept, step, finish, last;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HALF_W-1:0] l_q, l_d, r_q, r_d, rnd_l, rnd_r;
    logic              mode_q, mode_d;
    logic [BLK_W-1:0]  dout_q, dout_d, blk_in, result;
    logic              done_q, done_d;

    function automatic logic [HALF_W-1:0] rotl3(input logic [HALF_W-1:0] x);
        return {x[HALF_W-4:0], x[HALF_W-1:HALF_W-3]};
    endfunction

    assign last = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (bus.abort || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state_q)
            IDLE: accept = bus.start;
            RUN: begin
                step   = !bus.abort;
                finish = !bus.abort && last;
            end
            default: ;
        endcase
    end

    // Decrypt walks the key schedule backwards from the same counter.
    always_comb begin
        logic [HALF_W-1:0] l, r, t, k;
        int                idx;
        l   = l_q;
        r   = r_q;
        t   = '0;
        k   = '0;
        idx = 0;
        for (int j = 0; j < RPC; j++) begin
            idx = int'(cnt_q) + j;
            if (!mode_q) idx = ROUNDS - 1 - idx;
            k = bus.round_keys[idx*HALF_W +: HALF_W];
            t = l ^ (rotl3(r) ^ (r + k));
            l = r;
            r = t;
        end
        rnd_l = l;
        rnd_r = r;
    end

`ifdef FEISTEL_CBC_EN
    logic [BLK_W-1:0] chain_q, chain_d, cin_q, cin_d, chain_sel;

    // An IV loaded in the start cycle already applies to that block.
    assign chain_sel = bus.iv_load ? bus.iv_in : chain_q;
    assign blk_in    = bus.mode ? (bus.data_in ^ chain_sel) : bus.data_in;
    assign result    = mode_q ? {rnd_r, rnd_l} : ({rnd_r, rnd_l} ^ chain_q);

    always_comb begin
        chain_d = chain_q;
        cin_d   = cin_q;
        if (state_q == IDLE && bus.iv_load) chain_d = bus.iv_in;
        if (accept) cin_d = bus.data_in;
        if (finish) chain_d = mode_q ? result : cin_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            chain_q <= '0;
            cin_q   <= '0;
        end else begin
            chain_q <= chain_d;
            cin_q   <= cin_d;
        end
    end
`else
    assign blk_in = bus.data_in;
    assign result = {rnd_r, rnd_l};
`endif

    always_comb begin
        cnt_d  = cnt_q;
        l_d    = l_q;
        r_d    = r_q;
        mode_d = mode_q;
        dout_d = dout_q;
        done_d = 1'b0;
        if (accept) begin
            cnt_d  = '0;
            l_d    = blk_in[BLK_W-1:HALF_W];
            r_d    = blk_in[HALF_W-1:0];
            mode_d = bus.mode;
        end else if (step) begin
            cnt_d = cnt_q + STEP;
            l_d   = rnd_l;
            r_d   = rnd_r;
        end
        if (finish) begin
            dout_d = result;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            l_q    <= '0;
            r_q    <= '0;
            mode_q <= 1'b0;
            dout_q <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            l_q    <= l_d;
            r_q    <= r_d;
            mode_q <= mode_d;
            dout_q <= dout_d;
            done_q <= done_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.data_out = dout_q;
endmodule

// File: doc/feistel_engine.md
# feistel_engine

Parametrised iterative Feistel block-cipher engine, the next-generation replacement for the fixed 64-bit, 16-round DES datapath. The block width, round count and rounds-per-cycle unrolling are configurable, and the engine adds a busy/done handshake, abort, and optional CBC chaining. It sits between the packet buffer, which asserts `start` at end-of-packet, and the output stage, which consumes `data_out` on `done`. Round keys come pre-expanded from the key-schedule block.

## Interface
- `HALF_W`, default 32: half-block width; block is 2*HALF_W bits; legal range ≥4.
- `ROUNDS`, default 16: number of Feistel rounds; ≥1.
- `RPC`, default 1: rounds computed per clock; must divide `ROUNDS`. Define N = ROUNDS/RPC.
- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `start` in 1: request a block operation; sampled only while `busy`=0.
- `mode` in 1: 1 = encrypt, 0 = decrypt; captured with `start`.
- `abort` in 1: synchronous cancel of an in-flight operation.
- `data_in` in 2*HALF_W: input block {L,R}, L in the upper half; captured with `start`.
- `round_keys` in ROUNDS*HALF_W: key k at bits [k*HALF_W +: HALF_W]; must be held stable while `busy`=1 (not registered).
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse; `data_out` valid.
- `data_out` out 2*HALF_W: result; holds its value until the next `done`.
- `iv_load` in 1, present only with FEISTEL_CBC_EN: load chain register.
- `iv_in` in 2*HALF_W, present only with FEISTEL_CBC_EN: initial vector.

## Operation
- Round function: F(R,K) = rotl(R,3) ^ ((R + K) mod 2^HALF_W).
- One round maps (L,R) to (R, L ^ F(R,K)).
- Encrypt applies keys 0..ROUNDS-1. Decrypt applies keys ROUNDS-1..0.
- After the final round, output is {R,L}, i.e. halves swapped. Decrypt(Encrypt(x)) = x for the same key set.
- FSM states:
  - IDLE: on `start`, load L,R from `data_in`, latch `mode`, round counter := 0, go to RUN.
  - RUN: each cycle apply RPC consecutive rounds combinationally and advance the counter by RPC. On the cycle that completes round ROUNDS-1, register `data_out`, pulse `done`, and go to IDLE.
  - `abort` in RUN: go to IDLE with no `done`; `data_out` is unchanged.
  - `abort` in IDLE: ignored; a `start` in the same cycle is still accepted.
- `start` while `busy`=1 is ignored and is not queued.
- Reset values: `busy`=0, `done`=0, `data_out`=0, FSM=IDLE, counter=0, chain register=0.
- Reset mid-operation: immediate return to the reset values; no `done`.

## Timing
- `start` is sampled at edge E0. `busy`=1 after E0.
- Rounds are applied at edges E1..EN. `done`=1 and `data_out` are updated after EN, and `busy`=0 in that same cycle.
- Latency from the sampling edge to `done`: N cycles. With ROUNDS=16, RPC=1, this is 16; with RPC=4, it is 4.
- The earliest next `start` is sampled at EN+1, giving a throughput of one block per N+1 cycles.
- `done` lasts exactly one cycle.

## Configuration
- FEISTEL_CBC_EN defined: adds a 2*HALF_W-bit chain register and the `iv_load`/`iv_in` ports.
  - `iv_load` while IDLE: chain := `iv_in`. If `start` is in the same cycle, `iv_in` is used for that block.
  - `iv_load` while busy: ignored.
  - Encrypt: rounds operate on `data_in` ^ chain; at `done`, chain := `data_out`.
  - Decrypt: `data_out` = rounds(`data_in`) ^ chain; chain := captured `data_in` at `done`.
  - `abort` leaves the chain unchanged.
- FEISTEL_CBC_EN undefined: ports and register are absent; pure ECB behaviour as described under Operation.

## Test plan
- Known-answer test: HALF_W=4, ROUNDS=2, RPC=1, keys=0, encrypt `data_in`=8'h10. Required: `done` 2 cycles after the sampling edge, `data_out`=8'h91.
- Round trip: HALF_W=32, ROUNDS=16, encrypt 64'h1122334455667788 with key k = 32'h01010101*(k+1). Then decrypt the result with the same keys. Required: output 64'h1122334455667788; `done` 16 cycles after each start.
- Unrolling: same vector with RPC=4 and RPC=16. Required: `data_out` identical to RPC=1; latency 4 and 1 respectively.
- Handshake boundaries:
  - `start` pulsed while busy: ignored, single `done`.
  - `abort` at cycle 5: no `done`, `data_out` unchanged, new `start` accepted the next cycle.
  - `n_rst` low mid-run: all outputs 0.
- CBC (FEISTEL_CBC_EN): load IV 64'hFFFFFFFFFFFFFFFF, encrypt blocks 64'h0 then 64'h0. Required: the two ciphertexts differ. Reload the IV and decrypt both ciphertexts: both return 64'h0.
